// File: rtl/serial_demux_deserializer.sv
// Bit-serial to word deserializer: each accepted bit lands at position idx of an
// N-bit word, and the word is handed downstream when full or when in_last is seen.
module serial_demux_deserializer #(
  parameter int N  = 6,
  parameter int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_bit,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [N-1:0]  out_word,
  output logic [CW-1:0] out_len,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic {FILL, FULL} state_t;

  state_t        state;
  logic [CW-1:0] idx;
  logic [N-1:0]  word;
  logic [N-1:0]  wr_sel;
  logic          accept;
  logic          done;

  // One-hot decode of idx: the inverse of the selector's tree mux.
  for (genvar i = 0; i < N; i++) begin : g_sel
    assign wr_sel[i] = (idx == CW'(i));
  end

  assign accept   = in_valid && in_ready;
  assign done     = (idx == CW'(N-1)) || in_last;
  assign out_word = word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      word      <= '0;
      out_len   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            word <= (word & ~wr_sel) | (in_bit ? wr_sel : '0);
            if (done) begin
              state     <= FULL;
              out_len   <= idx + CW'(1);
              idx       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              idx <= idx + CW'(1);
            end
          end
        end
        FULL: begin
          // Source must hold its bit here; it is taken the first cycle back in FILL.
          if (out_ready) begin
            state     <= FILL;
            word      <= '0;
            out_len   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= FILL;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_demux_deserializer.sv
// Directed and randomized bench for serial_demux_deserializer against a queue-based model.
module tb_serial_demux_deserializer;
  localparam int N  = 6;
  localparam int CW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          rst, in_bit, in_valid, in_last, out_ready;
  logic          in_ready, out_valid;
  logic [N-1:0]  out_word;
  logic [CW-1:0] out_len;

  int checks = 0;
  int errors = 0;

  serial_demux_deserializer #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_word(out_word), .out_len(out_len),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Model: collected bits of the word in progress, and the word on offer if any.
  bit            q[$];
  bit            m_full = 0;
  bit            m_started = 0;
  logic [N-1:0]  m_word = '0;
  int            m_len = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete(); m_full = 0; m_word = '0; m_len = 0; m_started = 1;
    end else if (m_full) begin
      if (out_ready) begin m_full = 0; m_word = '0; m_len = 0; end
    end else if (in_valid) begin
      q.push_back(in_bit);
      m_word = '0;
      foreach (q[k]) m_word[k] = q[k];
      if (q.size() == N || in_last) begin
        m_full = 1; m_len = q.size(); q.delete();
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready",  {31'b0, in_ready},  {31'b0, !m_full});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_full});
      chk("out_word",  {{(32-N){1'b0}}, out_word}, {{(32-N){1'b0}}, m_word});
      chk("out_len",   {{(32-CW){1'b0}}, out_len}, m_len);
    end
  end

  task automatic cyc(input logic v, input logic b, input logic l, input logic ordy, input logic r);
    in_valid = v; in_bit = b; in_last = l; out_ready = ordy; rst = r;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [N-1:0] w);
    for (int i = 0; i < N; i++) cyc(1'b1, w[i], 1'b0, 1'b0, 1'b0);
  endtask

  logic [N-1:0] words [3];
  logic [N-1:0] got   [3];

  initial begin
    rst = 1; in_bit = 0; in_valid = 0; in_last = 0; out_ready = 0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
    chk("rst_word", out_word, 0);     chk("rst_len", out_len, 0);

    // six bits, LSB first, consumer not ready
    send_word(6'b001101);
    chk("w6_valid", out_valid, 1); chk("w6_word", out_word, 6'b001101);
    chk("w6_len", out_len, 6);     chk("w6_in_ready", in_ready, 0);
    chk("model_pin_w6", m_word, 6'b001101);
    cyc(1, 0, 0, 0, 0);
    chk("hold_valid", out_valid, 1); chk("hold_word", out_word, 6'b001101);
    cyc(0, 0, 0, 1, 0);
    chk("consume_valid", out_valid, 0); chk("consume_word", out_word, 0);

    // short word via in_last, then a full word with no stale bits
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("w2_word", out_word, 6'b000011); chk("w2_len", out_len, 2);
    chk("model_pin_len2", m_len, 2);
    cyc(0, 0, 0, 1, 0);
    chk("w2_consumed", out_valid, 0);
    send_word(6'b111111);
    chk("ones_word", out_word, 6'b111111); chk("ones_len", out_len, 6);
    cyc(0, 0, 0, 1, 0);

    // in_last on the very first bit
    cyc(1, 1, 1, 0, 0);
    chk("w1_valid", out_valid, 1); chk("w1_word", out_word, 6'b000001); chk("w1_len", out_len, 1);
    cyc(0, 0, 0, 1, 0);

    // back-to-back streaming with both sides always willing
    begin
      int cycles = 0, nw = 0, p = 0, w = 0;
      logic acc, cons;
      words[0] = 6'b101010; words[1] = 6'b010101; words[2] = 6'b111000;
      while (nw < 3 && cycles < 100) begin
        in_valid = (w < 3); in_bit = (w < 3) ? words[w][p] : 1'b0;
        in_last = 0; out_ready = 1; rst = 0;
        acc = in_ready; cons = out_valid;
        if (cons) got[nw] = out_word;
        @(posedge clk); #1;
        cycles++;
        if (acc && w < 3) begin p++; if (p == N) begin p = 0; w++; end end
        if (cons) nw++;
      end
      chk("stream_cycles", cycles, 21);
      chk("stream_w0", got[0], 6'b101010);
      chk("stream_w1", got[1], 6'b010101);
      chk("stream_w2", got[2], 6'b111000);
    end
    cyc(0, 0, 0, 0, 0);

    // reset mid-word
    cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    chk("midrst_ready", in_ready, 1); chk("midrst_valid", out_valid, 0); chk("midrst_word", out_word, 0);
    send_word(6'b110100);
    chk("post_rst_word", out_word, 6'b110100); chk("post_rst_len", out_len, 6);
    cyc(0, 0, 0, 1, 0);

    // pulses while FULL are ignored, then reset discards the word
    send_word(6'b011011);
    cyc(1, 1, 1, 0, 0); cyc(1, 0, 0, 0, 0);
    chk("full_ignore_word", out_word, 6'b011011); chk("full_ignore_len", out_len, 6);
    cyc(0, 0, 0, 0, 1);
    chk("fullrst_valid", out_valid, 0); chk("fullrst_word", out_word, 0); chk("fullrst_len", out_len, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);

    cyc(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
